// File: rtl/conv1d_engine.sv
// conv1d_engine
//   Sequencer/datapath wrapped around a 2^ADDR_W x DATA_W word memory.
//
//   On start, the engine:
//     - loads a KER_LEN-tap kernel;
//     - computes a valid-mode 1-D correlation over IN_LEN input samples;
//     - writes the N_OUT = IN_LEN-KER_LEN+1 results back to memory;
//     - pulses mem_write_all so the memory dumps its contents.
//
//   Ports:
//     clk             rising-edge clock
//     rst             synchronous reset, active-high
//     start           one-cycle request, honoured only in IDLE
//     mem_out         combinational read data, mem[mem_index]
//     mem_index       registered memory address (read and write)
//     mem_write       registered write strobe
//     mem_write_data  registered write data
//     mem_write_all   one-cycle dump pulse
//     busy            high from the cycle after start until DONE exits
//     done            one-cycle pulse, coincident with mem_write_all
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start
//   LOAD_K | reading kernel tap j from KER_BASE+j
//   MAC    | accumulating x[i+j]*k[j] for output i
//   WRITE  | mem_write strobe for y[i] at OUT_BASE+i
//   DONE   | mem_write_all/done pulse, then back to IDLE
module conv1d_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7,
  parameter int IN_BASE  = 0,
  parameter int IN_LEN   = 16,
  parameter int KER_BASE = 16,
  parameter int KER_LEN  = 3,
  parameter int OUT_BASE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] mem_index,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_all,
  output logic              busy,
  output logic              done
);

  localparam int N_OUT = IN_LEN - KER_LEN + 1;
  localparam int IW    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam logic [2:0]    J_LAST = 3'(KER_LEN - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);

  if (KER_LEN < 1 || KER_LEN > 8 || KER_LEN > IN_LEN) begin : g_bad_params
    $error("conv1d_engine: KER_LEN must be in 1..8 and not exceed IN_LEN");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0]        j_q, j_d;
  logic [IW-1:0]     i_q, i_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] wdata_d;
  logic [ADDR_W-1:0] idx_d;
  logic [DATA_W-1:0] k_q [8];
  logic [DATA_W-1:0] k_d [8];
  logic [DATA_W-1:0] prod, acc_sum;

  // Low DATA_W bits of a two's-complement product do not depend on operand
  // signedness, so a plain same-width multiply gives the wrapped result.
  assign prod    = mem_out * k_q[j_q];
  assign acc_sum = acc_q + prod;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    acc_d   = acc_q;
    wdata_d = mem_write_data;
    k_d     = k_q;
    idx_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_K;
          j_d     = '0;
        end
      end
      S_LOAD_K: begin
        k_d[j_q] = mem_out;
        if (j_q == J_LAST) begin
          state_d = S_MAC;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (j_q == J_LAST) begin
          state_d = S_WRITE;
          wdata_d = acc_sum;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      S_WRITE: begin
        if (i_q != I_LAST) begin
          state_d = S_MAC;
          i_d     = i_q + IW'(1);
          j_d     = '0;
          acc_d   = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The address is registered, so it is derived from the next state so that
    // it is already valid during the cycle that consumes mem_out.
    case (state_d)
      S_LOAD_K: idx_d = ADDR_W'(KER_BASE) + ADDR_W'(j_d);
      S_MAC:    idx_d = ADDR_W'(IN_BASE) + ADDR_W'(i_d) + ADDR_W'(j_d);
      S_WRITE:  idx_d = ADDR_W'(OUT_BASE) + ADDR_W'(i_d);
      default:  idx_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      j_q            <= '0;
      i_q            <= '0;
      acc_q          <= '0;
      mem_index      <= '0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
      mem_write_all  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      for (int t = 0; t < 8; t++) k_q[t] <= '0;
    end else begin
      state_q        <= state_d;
      j_q            <= j_d;
      i_q            <= i_d;
      acc_q          <= acc_d;
      mem_index      <= idx_d;
      mem_write      <= (state_d == S_WRITE);
      mem_write_data <= wdata_d;
      mem_write_all  <= (state_d == S_DONE);
      busy           <= (state_d != S_IDLE);
      done           <= (state_d == S_DONE);
      k_q            <= k_d;
    end
  end

endmodule
